// File: rtl/md_ctrl_if.sv
// Pipeline-facing bundle for the multiply/divide sequencer.
// The E-stage controls and D-stage hazard input go in; busy, stall and HI/LO come out.
interface md_ctrl_if;
  logic        E_MDStart;
  logic [1:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_HIWE;
  logic        E_LOWE;
  logic        D_UseMD;
  logic        MD_Busy;
  logic        MD_Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_MDStart, E_MDOp, E_A, E_B, E_HIWE, E_LOWE, D_UseMD,
    input  MD_Busy, MD_Stall, HI, LO
  );

  modport slave (
    input  E_MDStart, E_MDOp, E_A, E_B, E_HIWE, E_LOWE, D_UseMD,
    output MD_Busy, MD_Stall, HI, LO
  );
endinterface

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: latches the result on start, stays busy for a fixed
// latency, then commits to HI/LO. Also handles mthi/mtlo and the D-stage stall.
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_ctrl_if.slave  md
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            pend_wr_q, pend_wr_d;

  // Combinational result for the operation presented with E_MDStart.
  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign prod_s  = {{32{md.E_A[31]}}, md.E_A} * {{32{md.E_B[31]}}, md.E_B};
  assign prod_u  = {32'd0, md.E_A} * {32'd0, md.E_B};
  assign divisor = (md.E_B == 32'd0) ? 32'd1 : md.E_B;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    case (md.E_MDOp)
      2'd0: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      2'd1: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      2'd2: begin
        if (md.E_B == 32'd0) begin
          res_wr = 1'b0;
        end else if (md.E_A == 32'h8000_0000 && md.E_B == 32'hFFFF_FFFF) begin
          // Overflow case: quotient wraps to the dividend, no trap.
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $signed(md.E_A) / $signed(divisor);
          res_hi = $signed(md.E_A) % $signed(divisor);
        end
      end
      default: begin
        if (md.E_B == 32'd0) begin
          res_wr = 1'b0;
        end else begin
          res_lo = md.E_A / divisor;
          res_hi = md.E_A % divisor;
        end
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      StIdle: begin
        if (md.E_MDStart) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_wr_d = res_wr;
          count_d   = md.E_MDOp[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          state_d   = StBusy;
        end else begin
          if (md.E_HIWE) hi_d = md.E_A;
          if (md.E_LOWE) lo_d = md.E_A;
        end
      end
      default: begin
        // Start and mthi/mtlo requests are ignored while busy.
        if (count_q == CntW'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          count_d = '0;
          state_d = StIdle;
        end else begin
          count_d = count_q - CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign md.MD_Busy  = (state_q == StBusy);
  assign md.MD_Stall = md.D_UseMD & (md.E_MDStart | md.MD_Busy);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model built from arithmetic and a busy countdown.
module tb_md_ctrl;

  logic clk;
  logic reset;
  md_ctrl_if bus ();

  md_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  bit          m_pv;
  int          m_left;

  function automatic void ref_calc(input logic [1:0] op, input logic [31:0] a, b,
                                   output logic [31:0] rh, rl, output bit wr);
    longint          sa, sb, ma, mb, q, r, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    rh = 32'd0;
    rl = 32'd0;
    case (op)
      2'd0: begin
        p  = sa * sb;
        rh = p[63:32];
        rl = p[31:0];
      end
      2'd1: begin
        pu = {32'd0, a} * {32'd0, b};
        rh = pu[63:32];
        rl = pu[31:0];
      end
      2'd2: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q  = ma / mb;
          r  = ma % mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          rl = q[31:0];
          rh = r[31:0];
        end
      end
      default: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          rl = a / b;
          rh = a % b;
        end
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check stall mid-cycle, clock, update model, check state.
  task automatic step(input bit rst, input bit st, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit hw, input bit lw, input bit use_md);
    reset         = rst;
    bus.E_MDStart = st;
    bus.E_MDOp    = op;
    bus.E_A       = a;
    bus.E_B       = b;
    bus.E_HIWE    = hw;
    bus.E_LOWE    = lw;
    bus.D_UseMD   = use_md;
    #1;
    chk("stall", {31'd0, bus.MD_Stall}, {31'd0, use_md & (st | (m_left > 0))});
    @(posedge clk);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_pv = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pv) begin
        m_hi = m_ph;
        m_lo = m_pl;
      end
    end else if (st) begin
      ref_calc(op, a, b, m_ph, m_pl, m_pv);
      m_left = op[1] ? 10 : 5;
    end else begin
      if (hw) m_hi = a;
      if (lw) m_lo = a;
    end
    #1;
    chk("busy", {31'd0, bus.MD_Busy}, {31'd0, m_left > 0});
    chk("hi", bus.HI, m_hi);
    chk("lo", bus.LO, m_lo);
  endtask

  task automatic idle(input int n, input bit use_md);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 32'd0, 32'd0, 0, 0, use_md);
  endtask

  initial begin
    m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_pv = 0; m_left = 0;

    // 1: reset for two cycles, then D_UseMD alone must not stall
    step(1, 0, 2'd0, 32'd0, 32'd0, 0, 0, 0);
    step(1, 0, 2'd0, 32'd0, 32'd0, 0, 0, 0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    step(0, 0, 2'd0, 32'd0, 32'd0, 0, 0, 1);

    // 2: mult / multu with 3 * -4
    step(0, 1, 2'd0, 32'd3, 32'hFFFF_FFFC, 0, 0, 0);
    idle(5, 0);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFF4);
    step(0, 1, 2'd1, 32'd3, 32'hFFFF_FFFC, 0, 0, 0);
    idle(5, 0);
    chk("multu_hi", bus.HI, 32'h0000_0002);
    chk("multu_lo", bus.LO, 32'hFFFF_FFF4);

    // 3: divides
    step(0, 1, 2'd3, 32'd17, 32'd5, 0, 0, 0);
    idle(10, 0);
    chk("divu_lo", bus.LO, 32'd3);
    chk("divu_hi", bus.HI, 32'd2);
    step(0, 1, 2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    idle(10, 0);
    chk("div_lo", bus.LO, 32'hFFFF_FFFD);
    chk("div_hi", bus.HI, 32'hFFFF_FFFF);
    step(0, 1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    idle(10, 0);
    chk("ovf_lo", bus.LO, 32'h8000_0000);
    chk("ovf_hi", bus.HI, 32'd0);

    // 4: mthi/mtlo preload, then divide by zero leaves them
    step(0, 0, 2'd0, 32'h11, 32'd0, 1, 0, 0);
    step(0, 0, 2'd0, 32'h22, 32'd0, 0, 1, 0);
    step(0, 1, 2'd2, 32'd1234, 32'd0, 0, 0, 0);
    idle(10, 0);
    chk("dz_hi", bus.HI, 32'h11);
    chk("dz_lo", bus.LO, 32'h22);

    // 5: stall window and ignored requests mid-busy
    step(0, 1, 2'd0, 32'd7, 32'd9, 0, 0, 1);
    idle(2, 1);
    step(0, 1, 2'd3, 32'hDEAD_BEEF, 32'd3, 1, 1, 1);
    idle(2, 1);
    idle(1, 1);
    chk("s5_lo", bus.LO, 32'd63);
    chk("s5_hi", bus.HI, 32'd0);
    idle(1, 0);

    // 6: reset aborts a divide; following mult completes
    step(0, 1, 2'd2, 32'd100, 32'd7, 0, 0, 0);
    idle(3, 0);
    step(1, 0, 2'd0, 32'd0, 32'd0, 0, 0, 0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    idle(10, 0);
    step(0, 1, 2'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
    idle(5, 0);
    chk("s6_hi", bus.HI, 32'd1);
    chk("s6_lo", bus.LO, 32'hFFFF_FFFE);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 9);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -($urandom_range(1, 9));
        default: ;
      endcase
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), a, b, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
